// File: rtl/display_update_ctrl.sv
// rtl/display_update_ctrl.sv - frame-synchronised number-set update controller with blink
// Updates are held until vblank entry, then committed to the shadow set that feeds the renderer.
module display_update_ctrl #(
   parameter int          V_ACTIVE     = 480,
   parameter int          BLINK_FRAMES = 30,
   parameter logic [3:0]  BLANK_CODE   = 4'hF
) (
   input  logic        clk_pix,
   input  logic        rst,
   input  logic [9:0]  sy,
   input  logic        upd_valid,
   input  logic [47:0] upd_data,
   input  logic [11:0] upd_blink,
   output logic        upd_ready,
   output logic [47:0] numbers_disp,
   output logic        frame_tick,
   output logic        commit_done
);

   localparam int              CW        = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CW-1:0]   CNT_LAST  = CW'(BLINK_FRAMES - 1);
   localparam logic [9:0]      V_FIRST   = 10'(V_ACTIVE);
   localparam logic [47:0]     ALL_BLANK = {12{BLANK_CODE}};

   typedef enum logic {IDLE, PENDING} state_t;

   state_t        state;
   logic          vblank, vblank_d, vblank_entry;
   logic          accept, do_commit, cnt_wrap;
   logic [47:0]   pend_data, shadow_data, next_data, masked;
   logic [11:0]   pend_mask, shadow_mask, next_mask;
   logic [CW-1:0] frame_cnt;
   logic          blink_phase, next_phase;

   assign vblank       = (sy >= V_FIRST);
   assign vblank_entry = vblank & ~vblank_d;
   assign accept       = upd_valid & upd_ready;
   assign do_commit    = (state == PENDING) & vblank_entry;
   assign cnt_wrap     = vblank_entry & (frame_cnt == CNT_LAST);
   assign next_phase   = blink_phase ^ cnt_wrap;
   assign next_data    = do_commit ? pend_data : shadow_data;
   assign next_mask    = do_commit ? pend_mask : shadow_mask;

   // Blink is applied to the post-commit values so the display lands with commit_done.
   always_comb begin
      masked = next_data;
      for (int k = 0; k < 12; k++) begin
         if (next_mask[k] & next_phase) begin
            masked[4*k +: 4] = BLANK_CODE;
         end
      end
   end

   always_ff @(posedge clk_pix) begin
      if (rst) begin
         state        <= IDLE;
         upd_ready    <= 1'b1;
         vblank_d     <= 1'b0;
         frame_tick   <= 1'b0;
         commit_done  <= 1'b0;
         pend_data    <= ALL_BLANK;
         pend_mask    <= '0;
         shadow_data  <= ALL_BLANK;
         shadow_mask  <= '0;
         frame_cnt    <= '0;
         blink_phase  <= 1'b0;
         numbers_disp <= ALL_BLANK;
      end else begin
         vblank_d     <= vblank;
         frame_tick   <= vblank_entry;
         commit_done  <= do_commit;
         shadow_data  <= next_data;
         shadow_mask  <= next_mask;
         blink_phase  <= next_phase;
         numbers_disp <= masked;
         if (vblank_entry) begin
            frame_cnt <= cnt_wrap ? '0 : frame_cnt + 1'b1;
         end
         case (state)
            IDLE: begin
               // An accept coinciding with vblank entry skips this frame's edge.
               if (accept) begin
                  pend_data <= upd_data;
                  pend_mask <= upd_blink;
                  upd_ready <= 1'b0;
                  state     <= PENDING;
               end
            end
            PENDING: begin
               if (do_commit) begin
                  upd_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               upd_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_display_update_ctrl.sv
// tb/tb_display_update_ctrl.sv - scoreboard bench for display_update_ctrl
// One clock per line, 525 lines per frame; monitor pops expected commits and models the display.
module tb_display_update_ctrl;

   localparam logic [47:0] ALL_F = 48'hFFFF_FFFF_FFFF;

   logic        clk_pix = 1'b0;
   logic        rst = 1'b1;
   logic [9:0]  sy = 10'd0;
   logic        upd_valid = 1'b0;
   logic [47:0] upd_data = '0;
   logic [11:0] upd_blink = '0;
   logic        upd_ready;
   logic [47:0] numbers_disp;
   logic        frame_tick;
   logic        commit_done;

   always #5 clk_pix = ~clk_pix;

   display_update_ctrl #(
      .V_ACTIVE(480),
      .BLINK_FRAMES(2),
      .BLANK_CODE(4'hF)
   ) dut (
      .clk_pix(clk_pix),
      .rst(rst),
      .sy(sy),
      .upd_valid(upd_valid),
      .upd_data(upd_data),
      .upd_blink(upd_blink),
      .upd_ready(upd_ready),
      .numbers_disp(numbers_disp),
      .frame_tick(frame_tick),
      .commit_done(commit_done)
   );

   typedef struct {
      logic [47:0] data;
      logic [11:0] mask;
      int          entry;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          total = 0;
   int          bad = 0;
   int          entries = 0;
   int          ent_rst = 0;
   logic [47:0] sh_data = ALL_F;
   logic [11:0] sh_mask = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (sy=%0d t=%0t)", name, act, exp, sy, $time);
      end
   endtask

   function automatic logic [47:0] apply(input logic [47:0] d, input logic [11:0] m, input logic ph);
      logic [47:0] r;
      r = d;
      for (int k = 0; k < 12; k++) begin
         if (m[k] & ph) r[4*k +: 4] = 4'hF;
      end
      return r;
   endfunction

   // Entries are counted on line 481, the cycle in which the DUT's response to the edge is visible.
   task automatic tick();
      @(posedge clk_pix);
      #1;
      sy = (sy == 10'd524) ? 10'd0 : sy + 10'd1;
      if (sy == 10'd481) begin
         entries++;
         ent_rst++;
      end
   endtask

   task automatic goto_line(input int line);
      for (int n = 0; n < 600 && int'(sy) != line; n++) tick();
   endtask

   task automatic send(input logic [47:0] d, input logic [11:0] m);
      exp_t e;
      upd_valid = 1'b1;
      upd_data  = d;
      upd_blink = m;
      tick();
      upd_valid = 1'b0;
      e.data  = d;
      e.mask  = m;
      e.entry = entries + 1;
      sb.push_back(e);
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 1200 && sb.size() != 0; n++) tick();
      if (sb.size() != 0) begin
         check("commit_timeout", 64'(sb.size()), 64'd0);
         sb.delete();
      end
   endtask

   always @(negedge clk_pix) begin
      if (rst) begin
         sh_data = ALL_F;
         sh_mask = '0;
      end else begin
         if (commit_done) begin
            if (sb.size() == 0) begin
               check("commit_unexpected", 64'd1, 64'd0);
            end else begin
               mon_e = sb.pop_front();
               check("commit_entry", 64'(mon_e.entry), 64'(entries));
               sh_data = mon_e.data;
               sh_mask = mon_e.mask;
            end
         end
         check("frame_tick", 64'(frame_tick), 64'(sy == 10'd481));
         check("upd_ready", 64'(upd_ready), 64'(sb.size() == 0));
         check("numbers_disp", 64'(numbers_disp), 64'(apply(sh_data, sh_mask, ent_rst[1])));
      end
   end

   initial begin
      repeat (3) tick();
      rst = 1'b0;
      repeat (1050) tick();

      goto_line(100);
      send(48'h0123_4567_89AB, 12'h000);
      wait_idle();

      goto_line(480);
      send(48'hA5A5_5A5A_1234, 12'h000);
      wait_idle();

      goto_line(490);
      send(48'h9876_5432_10BB, 12'h000);
      wait_idle();

      goto_line(100);
      send(48'h0123_4567_89AB, 12'h001);
      wait_idle();
      repeat (4 * 525) tick();
      goto_line(300);
      send(48'h5555_5555_555B, 12'h001);
      wait_idle();
      repeat (3 * 525) tick();

      goto_line(100);
      send(48'h1111_1111_1111, 12'h000);
      goto_line(200);
      rst = 1'b1;
      sb.delete();
      ent_rst = 0;
      tick();
      rst = 1'b0;
      repeat (700) tick();

      check("queue_empty", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
